pin_array_deser: RTL and testbench

//   Parametrised successor to the fixed 4-lane pin array fan-out/fan-in netlist.

---
 rtl/pin_array_pkg.sv | 8 +
 rtl/pin_array_lane.sv | 18 +
 rtl/pin_array_deser.sv | 79 +++++++
 tb/tb_pin_array_deser.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pin_array_pkg.sv
// pin_array_pkg: shared lane limit, pointer type and lane-mapping helper for the pin array deserializer.
package pin_array_pkg;
  localparam int PIN_ARRAY_MAX_LANE = 64;
  typedef logic [$clog2(PIN_ARRAY_MAX_LANE)-1:0] ptr_t;
  function automatic ptr_t lane_idx(input ptr_t ptr, input int n, input logic msb_first);
    return msb_first ? ptr_t'(n - 1) - ptr : ptr;
  endfunction
endpackage

// File: rtl/pin_array_lane.sv
// pin_array_lane: one lane register of the pin array.
//   clk, rst_n : clock, async active-low reset
//   clr        : sync clear (wins over load)
//   load, d    : capture d when load=1
//   q          : lane value
module pin_array_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (load) q <= d;
endmodule

// File: rtl/pin_array_deser.sv
// pin_array_deser: round-robin serial-to-parallel deserializer with valid/ready output buffer and sticky overflow.
//   clk, rst_n        : clock, async active-low reset
//   VDD, VSS          : schematic supply pins, no function
//   vin, en, clr      : serial sample, sample strobe, sync clear of partial word and ovf
//   mid               : lane registers
//   vout, vout_valid  : assembled word and its valid flag; vout_ready accepts it
//   ovf               : sticky dropped-word flag
//   vout_par          : ^vout, present only with PIN_ARRAY_DESER_PARITY_EN defined
module pin_array_deser #(
  parameter int N_LANE    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              VDD,
  input  logic              VSS,
  input  logic              vin,
  input  logic              en,
  input  logic              clr,
  output logic [N_LANE-1:0] mid,
  output logic [N_LANE-1:0] vout,
  output logic              vout_valid,
  input  logic              vout_ready,
  output logic              ovf
`ifdef PIN_ARRAY_DESER_PARITY_EN
  ,output logic             vout_par
`endif
);
  import pin_array_pkg::*;
  localparam int PW = $clog2(N_LANE);
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [N_LANE-1:0] vout_q, load, word;
  logic              vout_valid_q, ovf_q, last, done, xfer, unused_pins;
  ptr_t              lane;
  assign unused_pins = VDD ^ VSS;
  assign last  = ptr_q == PW'(N_LANE - 1);
  assign done  = en & ~clr & last;
  assign xfer  = vout_valid_q & vout_ready;
  assign lane  = lane_idx(ptr_t'(ptr_q), N_LANE, MSB_FIRST);
  assign ptr_d = clr ? '0 : !en ? ptr_q : last ? '0 : ptr_q + PW'(1);
  // The completed word bypasses the lane registers so the final sample is included on the same edge.
  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    assign load[i] = en & (lane == ptr_t'(i));
    assign word[i] = load[i] ? vin : mid[i];
    pin_array_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .load (load[i]),
      .d    (vin),
      .q    (mid[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr_q        <= '0;
      vout_q       <= '0;
      vout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (done && (!vout_valid_q || vout_ready)) begin
        vout_q       <= word;
        vout_valid_q <= 1'b1;
      end else if (xfer) vout_valid_q <= 1'b0;
      if (clr) ovf_q <= 1'b0;
      else if (done && vout_valid_q && !vout_ready) ovf_q <= 1'b1;
    end
`ifdef PIN_ARRAY_DESER_PARITY_EN
  logic vout_par_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vout_par_q <= 1'b0;
    else if (done && (!vout_valid_q || vout_ready)) vout_par_q <= ^word;
  assign vout_par = vout_par_q;
`endif
  assign vout       = vout_q;
  assign vout_valid = vout_valid_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_pin_array_deser.sv
// tb_pin_array_deser: scoreboard bench driving an LSB-first and an MSB-first deserializer with shared stimulus.
module tb_pin_array_deser;
  logic clk = 1'b0, rst_n = 1'b0, vin = 1'b0, en = 1'b0, clr = 1'b0, vout_ready = 1'b0;
  logic VDD = 1'b1, VSS = 1'b0;
  logic [3:0] mid_a, vout_a, mid_b, vout_b;
  logic val_a, ovf_a, val_b, ovf_b;
`ifdef PIN_ARRAY_DESER_PARITY_EN
  logic par_a, par_b;
`endif
  int vectors = 0, miscompares = 0;
  logic [3:0] qa[$], qb[$];
  logic [3:0] mmid;
  int mptr;
  logic mvalid, movf;
  always #5 clk = ~clk;
  pin_array_deser #(.N_LANE(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .VDD(VDD), .VSS(VSS), .vin(vin), .en(en), .clr(clr),
    .mid(mid_a), .vout(vout_a), .vout_valid(val_a), .vout_ready(vout_ready), .ovf(ovf_a)
`ifdef PIN_ARRAY_DESER_PARITY_EN
    , .vout_par(par_a)
`endif
  );
  pin_array_deser #(.N_LANE(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .VDD(VDD), .VSS(VSS), .vin(vin), .en(en), .clr(clr),
    .mid(mid_b), .vout(vout_b), .vout_valid(val_b), .vout_ready(vout_ready), .ovf(ovf_b)
`ifdef PIN_ARRAY_DESER_PARITY_EN
    , .vout_par(par_b)
`endif
  );
  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    mmid = '0;
    mptr = 0;
    mvalid = 1'b0;
    movf = 1'b0;
    qa.delete();
    qb.delete();
  endtask
  task automatic step(input logic e, input logic v, input logic r, input logic c);
    logic [3:0] w;
    logic dn, acc, xf;
    en = e;
    vin = v;
    vout_ready = r;
    clr = c;
    #1;
    if (val_a && r) begin
      chk("qa_nonempty", 32'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        w = qa.pop_front();
        chk("vout_lsb", vout_a, w);
`ifdef PIN_ARRAY_DESER_PARITY_EN
        chk("par_lsb", par_a, ^w);
`endif
      end
    end
    if (val_b && r) begin
      chk("qb_nonempty", 32'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        w = qb.pop_front();
        chk("vout_msb", vout_b, w);
`ifdef PIN_ARRAY_DESER_PARITY_EN
        chk("par_msb", par_b, ^w);
`endif
      end
    end
    xf = mvalid && r;
    dn = e && !c && mptr == 3;
    acc = dn && (!mvalid || r);
    if (dn && mvalid && !r) movf = 1'b1;
    if (c) begin
      mptr = 0;
      mmid = '0;
      movf = 1'b0;
    end else if (e) begin
      mmid[mptr] = v;
      mptr = (mptr == 3) ? 0 : mptr + 1;
    end
    if (acc) begin
      qa.push_back(mmid);
      qb.push_back(rev4(mmid));
      mvalid = 1'b1;
    end else if (xf) mvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("valid_lsb", val_a, mvalid);
    chk("valid_msb", val_b, mvalid);
    chk("ovf_lsb", ovf_a, movf);
    chk("ovf_msb", ovf_b, movf);
    chk("mid_lsb", mid_a, mmid);
    chk("mid_msb", mid_b, rev4(mmid));
  endtask
  task automatic send4(input logic [3:0] bits, input logic r);
    for (int i = 0; i < 4; i++) step(1'b1, bits[i], r, 1'b0);
  endtask
  initial begin
    model_reset();
    #12;
    chk("rst_mid", mid_a, 0);
    chk("rst_vout", vout_a, 0);
    chk("rst_valid", val_a, 0);
    chk("rst_ovf", ovf_a, 0);
    rst_n = 1'b1;
    // T1/T2: stream 1,0,1,1
    send4(4'b1101, 1'b1);
    chk("t1_vout_lsb", vout_a, 4'b1101);
    chk("t2_vout_msb", vout_b, 4'b1011);
`ifdef PIN_ARRAY_DESER_PARITY_EN
    chk("t6_par", par_a, 1);
`endif
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_valid_one_cycle", val_a, 0);
    // T3: overflow while stalled, clr, then drain
    send4(4'b1101, 1'b0);
    send4(4'b0000, 1'b0);
    chk("t3_ovf", ovf_a, 1);
    chk("t3_vout_held", vout_a, 4'b1101);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovf_clr", ovf_a, 0);
    chk("t3_valid_kept", val_a, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_vout_xfer", vout_a, 4'b1101);
    // T4: gaps in en
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_vout", vout_a, 4'b1101);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    // T5: async reset mid-word
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_mid", mid_a, 0);
    chk("t5_valid", val_a, 0);
    chk("t5_vout", vout_a, 0);
    model_reset();
    #1 rst_n = 1'b1;
    send4(4'b0110, 1'b1);
    chk("t5_word", vout_a, 4'b0110);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    // clr discards a simultaneous sample
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_mid", mid_a, 0);
    // T6: back-to-back words, transfer and completion on the same edge
    send4(4'b1101, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("b2b_valid", val_a, 1);
    chk("b2b_vout", vout_a, 4'b1111);
`ifdef PIN_ARRAY_DESER_PARITY_EN
    chk("b2b_par", par_a, 0);
`endif
    step(1'b0, 1'b0, 1'b1, 1'b0);
    // random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("qa_left", qa.size(), 0);
    chk("qb_left", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
